// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle between a command producer/result consumer and the sequencer.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_b;
  logic       cmd_load;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_zero;
  logic       res_carry;

  modport master (
    output cmd_valid, cmd_op, cmd_b, cmd_load, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, res_carry
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_b, cmd_load, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_carry
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers {op, operand} commands, drives them into an external combinational 4-bit ALU
// against an accumulator, and reports each captured result on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [3:0]  ACC_INIT = 4'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_cmd_sequencer_if.slave       bus,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [2:0]               alu_op,
  input  logic [3:0]               alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_carry,
  output logic [3:0]               acc,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic       load;
    logic [2:0] op;
    logic [3:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, OUT} state_t;

  state_t          state, state_nxt;
  cmd_t            mem [DEPTH];
  cmd_t            head_c;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_nxt_c;
  logic            push_c, pop_c, exec_c, clr_c, ack_c, nonempty_c;
  logic            load_q;
  logic [3:0]      exec_data_c;
  logic            exec_zero_c, exec_carry_c;

  assign push_c      = bus.cmd_valid && bus.cmd_ready;
  assign ack_c       = bus.res_valid && bus.res_ready;
  assign nonempty_c  = (fifo_count != CW'(0));
  assign head_c      = mem[rd_ptr];
  assign count_nxt_c = fifo_count + CW'(push_c) - CW'(pop_c);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (nonempty_c) state_nxt = EXEC;
      EXEC:    state_nxt = OUT;
      OUT:     if (ack_c) state_nxt = nonempty_c ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM control strobes
  always_comb begin
    pop_c  = 1'b0;
    exec_c = 1'b0;
    clr_c  = 1'b0;
    case (state)
      IDLE: pop_c = nonempty_c;
      EXEC: exec_c = 1'b1;
      OUT: begin
        clr_c = ack_c;
        pop_c = ack_c && nonempty_c;
      end
      default: ;
    endcase
  end

  // A load bypasses the ALU and takes the operand itself
  always_comb begin
    exec_data_c  = load_q ? alu_b : alu_result;
    exec_zero_c  = load_q ? (alu_b == 4'h0) : alu_zero;
    exec_carry_c = load_q ? 1'b0 : alu_carry;
  end

  // Command storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= cmd_t'{load: bus.cmd_load, op: bus.cmd_op, b: bus.cmd_b};
  end

  // FIFO pointers and occupancy; ready is registered from the next count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      bus.cmd_ready <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count    <= count_nxt_c;
      bus.cmd_ready <= (count_nxt_c != CW'(DEPTH));
    end
  end

  // Issue, capture and result presentation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a         <= 4'h0;
      alu_b         <= 4'h0;
      alu_op        <= 3'h0;
      load_q        <= 1'b0;
      acc           <= ACC_INIT;
      bus.res_valid <= 1'b0;
      bus.res_data  <= ACC_INIT;
      bus.res_zero  <= 1'b0;
      bus.res_carry <= 1'b0;
    end else begin
      if (pop_c) begin
        alu_a  <= acc;
        alu_b  <= head_c.b;
        alu_op <= head_c.op;
        load_q <= head_c.load;
      end
      if (exec_c) begin
        acc           <= exec_data_c;
        bus.res_data  <= exec_data_c;
        bus.res_zero  <= exec_zero_c;
        bus.res_carry <= exec_carry_c;
        bus.res_valid <= 1'b1;
      end else if (clr_c) begin
        bus.res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: an arithmetic reference model predicts each result at command acceptance;
// a monitor pops and compares on every result handshake.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH    = 4;
  localparam logic [3:0]  ACC_INIT = 4'h0;
  localparam int unsigned CW       = $clog2(DEPTH) + 1;

  typedef struct {
    int data;
    int zero;
    int carry;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic [3:0]    alu_a, alu_b, alu_result, acc;
  logic [2:0]    alu_op;
  logic          alu_zero, alu_carry;
  logic [CW-1:0] fifo_count;
  logic [4:0]    alu_wide;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ACC_INIT(ACC_INIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .acc        (acc),
    .fifo_count (fifo_count)
  );

  // External ALU: 000 ADD 001 SUB 010 AND 011 OR 100 XOR 101 NOT(A) 110 NAND 111 NOR
  always_comb begin
    alu_wide = 5'h0;
    case (alu_op)
      3'd0: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_wide = {1'b0, alu_a & alu_b};
      3'd3: alu_wide = {1'b0, alu_a | alu_b};
      3'd4: alu_wide = {1'b0, alu_a ^ alu_b};
      3'd5: alu_wide = {1'b0, ~alu_a};
      3'd6: alu_wide = {1'b0, ~(alu_a & alu_b)};
      default: alu_wide = {1'b0, ~(alu_a | alu_b)};
    endcase
    alu_result = alu_wide[3:0];
    alu_carry  = alu_wide[4];
    alu_zero   = (alu_wide[3:0] == 4'h0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rdy_mode = 2;
  int   acc_m = 0;
  bit   spacing_en = 1'b0;
  exp_t exp_q[$];
  int   hs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: result of one command applied to the model accumulator
  function automatic exp_t model_step(input bit load, input int op, input int b);
    exp_t e;
    int   a = acc_m;
    int   r = 0;
    int   c = 0;
    if (load) begin
      r = b;
    end else begin
      case (op)
        0: begin r = a + b; c = (r > 15) ? 1 : 0; r = r % 16; end
        1: begin c = (a < b) ? 1 : 0; r = (a - b + 16) % 16; end
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: r = 15 - a;
        6: r = 15 - (a & b);
        default: r = 15 - (a | b);
      endcase
    end
    e.data  = r;
    e.zero  = (r == 0) ? 1 : 0;
    e.carry = c;
    acc_m   = r;
    return e;
  endfunction

  task automatic send(input bit load, input int op, input int b);
    bit done = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = load;
    bus.cmd_op    = 3'(op);
    bus.cmd_b     = 4'(b);
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus.cmd_ready) begin
        exp_q.push_back(model_step(load, op, b));
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    if (!done) check("cmd_accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Result ready driver: 0 always, 1 random, 2 never, 3 left to the main sequence
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.res_ready = 1'b1;
        1: bus.res_ready = 1'($urandom_range(0, 1));
        2: bus.res_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // Monitor: scoreboard compare on handshake, stability while stalled
  logic       stalled_prev = 1'b0;
  logic [3:0] hold_data;
  logic       hold_zero, hold_carry;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && bus.res_valid) begin
        check("stall_res_data", int'(bus.res_data), int'(hold_data));
        check("stall_res_zero", int'(bus.res_zero), int'(hold_zero));
        check("stall_res_carry", int'(bus.res_carry), int'(hold_carry));
      end
      if (bus.res_valid && bus.res_ready) begin
        check("res_expected_pending", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("res_data", int'(bus.res_data), e.data);
          check("res_zero", int'(bus.res_zero), e.zero);
          check("res_carry", int'(bus.res_carry), e.carry);
          check("acc_eq_res", int'(acc), e.data);
        end
        if (spacing_en) hs_q.push_back(cyc);
      end
      stalled_prev = bus.res_valid && !bus.res_ready;
      hold_data    = bus.res_data;
      hold_zero    = bus.res_zero;
      hold_carry   = bus.res_carry;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, int'(fifo_count), 0);
    check({tag, "_res_valid"}, int'(bus.res_valid), 0);
    check({tag, "_acc"}, int'(acc), int'(ACC_INIT));
    check({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
    check({tag, "_res_data"}, int'(bus.res_data), int'(ACC_INIT));
    check({tag, "_alu_a"}, int'(alu_a), 0);
    check({tag, "_alu_b"}, int'(alu_b), 0);
    check({tag, "_alu_op"}, int'(alu_op), 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'h0;
    bus.cmd_b     = 4'h0;
    bus.res_ready = 1'b0;
    acc_m         = int'(ACC_INIT);
    repeat (2) @(negedge clk);
    check_reset_state("rst0");
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD 9; ADD 8 -> 9 then 1 with carry
    rdy_mode = 0;
    send(1'b1, 0, 9);
    send(1'b0, 0, 8);
    drain();
    check("load_add_acc", int'(acc), 1);

    // LOAD 3; SUB 3; SUB 1 -> 3, 0 (zero), F (borrow)
    send(1'b1, 0, 3);
    send(1'b0, 1, 3);
    send(1'b0, 1, 1);
    drain();
    check("sub_chain_acc", int'(acc), 15);

    // LOAD A; AND 6; NOT; NOR F -> A, 2, D, 0
    send(1'b1, 0, 10);
    send(1'b0, 2, 6);
    send(1'b0, 5, 0);
    send(1'b0, 7, 15);
    drain();
    check("logic_acc", int'(acc), 0);
    check("logic_zero", int'(bus.res_zero), 1);

    // Stalled consumer: FIFO fills, ready drops, result held
    rdy_mode = 2;
    for (int i = 0; i < 5; i++) send(i == 0, 0, i + 1);
    repeat (2) @(negedge clk);
    check("full_count", int'(fifo_count), int'(DEPTH));
    check("full_cmd_ready", int'(bus.cmd_ready), 0);
    check("full_res_valid", int'(bus.res_valid), 1);
    repeat (6) @(negedge clk);
    rdy_mode = 0;
    drain();

    // Push and pop in the same cycle at count 2
    rdy_mode = 3;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 4, int'($urandom_range(0, 15)));
    repeat (4) @(negedge clk);
    check("pp_pre_count", int'(fifo_count), 2);
    check("pp_pre_valid", int'(bus.res_valid), 1);
    check("pp_pre_ready", int'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    bus.res_ready = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'd3;
    bus.cmd_b     = 4'h5;
    exp_q.push_back(model_step(1'b0, 3, 5));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    check("pp_post_count", int'(fifo_count), 2);
    rdy_mode = 0;
    drain();

    // Streaming: one result every 2 cycles
    hs_q.delete();
    spacing_en = 1'b1;
    for (int i = 0; i < 8; i++)
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    drain();
    spacing_en = 1'b0;
    check("stream_results", hs_q.size(), 8);
    for (int i = 1; i < hs_q.size(); i++) check("stream_spacing", hs_q[i] - hs_q[i-1], 2);

    // Random commands with random gaps and random consumer backpressure
    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      send(($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Reset while a command executes with three more queued
    rdy_mode = 3;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, 0, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    check("midexec_count", int'(fifo_count), 3);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_m = int'(ACC_INIT);
    @(negedge clk);
    check_reset_state("rst1");
    rst_n = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    send(1'b1, 0, 7);
    send(1'b0, 0, 1);
    drain();
    check("post_reset_acc", int'(acc), 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
